// File: rtl/zap_ifetch_wb_if.sv
// Wishbone B3 classic read-only bundle between the instruction-fetch bridge
// and the instruction bus slave.
interface zap_ifetch_wb_if;
  logic        cyc;
  logic        stb;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic        we;
  logic [31:0] dat;
  logic        ack;
  logic        err;

  modport master (
    output cyc, stb, adr, sel, we,
    input  dat, ack, err
  );

  modport slave (
    input  cyc, stb, adr, sel, we,
    output dat, ack, err
  );
endinterface

// File: rtl/zap_ifetch_wb.sv
// Single-word instruction fetch buffer: zero-stall hits, single-beat Wishbone
// reads on a miss, bus errors and watchdog timeouts become tagged aborts.
module zap_ifetch_wb #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_pc_ff,
  input  logic        i_fetch_en,
  input  logic        i_flush,
  output logic [31:0] o_instruction,
  output logic        o_valid,
  output logic        o_instr_abort,
  output logic        o_code_stall,
  zap_ifetch_wb_if.master wb
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t        state, state_nxt;
  logic          buf_v;
  logic [29:0]   buf_tag;
  logic [31:0]   buf_data;
  logic          buf_abt;
  logic [29:0]   req_addr;
  logic          drop;
  logic [TW-1:0] timer;

  logic hit, launch, timeout, resp_ack, resp_err, resp;

  assign hit      = buf_v && (buf_tag == i_pc_ff[31:2]);
  assign launch   = (state == IDLE) && !hit && i_fetch_en && !i_flush;
  assign timeout  = (TIMEOUT_CYCLES != 0) && (timer == TIMER_LAST);
  assign resp_ack = (state == WAIT) && wb.ack;
  assign resp_err = (state == WAIT) && !wb.ack && (wb.err || timeout);
  assign resp     = resp_ack || resp_err;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (launch) state_nxt = WAIT;
      WAIT: if (resp)   state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  // cyc/stb decode the one-bit state flop directly, so they are glitch-free.
  always_comb begin
    wb.cyc = (state == WAIT);
    wb.stb = (state == WAIT);
    wb.adr = {req_addr, 2'b00};
    wb.sel = 4'hF;
    wb.we  = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      buf_v    <= 1'b0;
      buf_tag  <= '0;
      buf_data <= '0;
      buf_abt  <= 1'b0;
      req_addr <= '0;
      drop     <= 1'b0;
      timer    <= '0;
    end else begin
      if (launch) begin
        req_addr <= i_pc_ff[31:2];
        drop     <= 1'b0;
        timer    <= '0;
      end
      if (state == WAIT) begin
        timer <= timer + TW'(1);
        if (i_flush) drop <= 1'b1;
      end
      // A flush coinciding with the response discards it as well.
      if (resp && !drop && !i_flush) begin
        buf_v    <= 1'b1;
        buf_tag  <= req_addr;
        buf_data <= resp_ack ? wb.dat : 32'h0;
        buf_abt  <= resp_err;
      end
      if (i_flush) buf_v <= 1'b0;
    end
  end

  always_comb begin
    o_valid       = hit;
    o_instruction = buf_data;
    o_instr_abort = buf_abt && hit;
    o_code_stall  = !hit;
  end

endmodule
